// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: arbitration phase and read-return owner tag.
package imem_pkg;

    typedef enum logic [0:0] {
        ARB_BOOT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_L    = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive denied loader cycles; at_max forces the next loader grant.
module imem_starve_cnt
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != LIMIT)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign at_max = (count_reg == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (read-only) and the loader port,
// and steers the one-cycle-late read data back to whichever side issued the read.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Boot_Done,
    input  logic              F_Req,
    input  logic [ADDR_W-1:0] F_Addr,
    input  logic              F_Flush,
    output logic              F_Gnt,
    output logic              F_RValid,
    output logic [DATA_W-1:0] F_RData,
    output logic              StallF_Arb,
    input  logic              L_Req,
    input  logic              L_We,
    input  logic [ADDR_W-1:0] L_Addr,
    input  logic [DATA_W-1:0] L_WData,
    output logic              L_Gnt,
    output logic              L_RValid,
    output logic [DATA_W-1:0] L_RData,
    output logic              M_En,
    output logic              M_We,
    output logic [ADDR_W-1:0] M_Addr,
    output logic [DATA_W-1:0] M_WData,
    input  logic [DATA_W-1:0] M_RData
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    arb_state_t state_reg, state_next;
    arb_owner_t tag_reg, tag_next;
    logic       f_win, l_win;
    logic       force_l;

    imem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (L_Req && !l_win),
        .clr    (l_win || !L_Req),
        .at_max (force_l)
    );

    // Grants are held low during reset so nothing reaches memory while the arbiter restarts.
    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
        if (!rst) begin
            if (state_reg == ARB_BOOT) begin
                l_win = L_Req;
            end else begin
                l_win = L_Req && (!F_Req || force_l);
                f_win = F_Req && !l_win;
            end
        end
    end

    always_comb begin
        M_Addr  = '0;
        M_WData = '0;
        if (f_win) begin
            M_Addr = F_Addr & WORD_MASK;
        end else if (l_win) begin
            M_Addr = L_Addr & WORD_MASK;
            if (L_We) begin
                M_WData = L_WData;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if ((state_reg == ARB_BOOT) && Boot_Done) begin
            state_next = ARB_RUN;
        end
        tag_next = OWN_NONE;
        if (f_win) begin
            tag_next = OWN_F;
        end else if (l_win && !L_We) begin
            tag_next = OWN_L;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB_BOOT;
            tag_reg   <= OWN_NONE;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
        end
    end

    assign F_Gnt      = f_win;
    assign L_Gnt      = l_win;
    assign StallF_Arb = F_Req && !f_win;
    assign M_En       = f_win || l_win;
    assign M_We       = l_win && L_We;

    // A read issued just before reset, or a fetch read squashed by a redirect, never reports valid.
    assign F_RValid = !rst && (tag_reg == OWN_F) && !F_Flush;
    assign L_RValid = !rst && (tag_reg == OWN_L);
    assign F_RData  = F_RValid ? M_RData : '0;
    assign L_RData  = L_RValid ? M_RData : '0;

endmodule
